// File: rtl/pc_stack.sv
// pc_stack: program counter with a return-address stack (jump/call/ret, sticky overflow/underflow flags)
// ports: clk, rst (async, active-high); en advances state; jump/call/ret request ops (ret > call > jump > increment);
//        clr_err clears ovf/unf; target is the jump/call destination; q is the registered PC;
//        sp counts valid stack entries; full/empty decode sp; ovf/unf flag call-while-full and ret-while-empty
module pc_stack #(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 4,
    parameter int RESET_VECTOR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         jump,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         clr_err,
    input  logic [WIDTH-1:0]             target,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] q_inc, q_nxt;
    logic [SW-1:0]    sp_nxt;
    logic [IW-1:0]    top, wr;
    logic             pop, push, jmp, ovf_ev, unf_ev;
    assign full  = sp == SW'(DEPTH);
    assign empty = sp == '0;
    always_comb begin
        q_inc  = q + WIDTH'(1);
        top    = IW'(sp - SW'(1));
        wr     = IW'(sp);
        pop    = en & ret & ~empty;
        unf_ev = en & ret & empty;
        push   = en & ~ret & call & ~full;
        ovf_ev = en & ~ret & call & full;
        jmp    = en & ~ret & ~call & jump;
        // failed call/ret fall through to the increment path
        q_nxt  = !en ? q : pop ? stack[top] : (push | jmp) ? target : q_inc;
        sp_nxt = pop ? sp - SW'(1) : push ? sp + SW'(1) : sp;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= WIDTH'(RESET_VECTOR);
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            q   <= q_nxt;
            sp  <= sp_nxt;
            ovf <= ovf_ev | (ovf & ~clr_err);
            unf <= unf_ev | (unf & ~clr_err);
        end
    end
    // storage is deliberately left unreset; entries at or above sp are never read
    always_ff @(posedge clk) begin
        if (push) stack[wr] <= q_inc;
    end
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: table-driven and randomised scoreboard bench for pc_stack (WIDTH=4, DEPTH=4)
module tb_pc_stack;
    logic       clk = 1'b0;
    logic       rst, en, jump, call, ret, clr_err;
    logic [3:0] target, q;
    logic [2:0] sp;
    logic       full, empty, ovf, unf;
    pc_stack #(.WIDTH(4), .DEPTH(4), .RESET_VECTOR(0)) dut (
        .clk(clk), .rst(rst), .en(en), .jump(jump), .call(call), .ret(ret), .clr_err(clr_err),
        .target(target), .q(q), .sp(sp), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic       en, jump, call, ret, clr;
        logic [3:0] target;
        logic [3:0] q;
        logic [2:0] sp;
        logic       ovf, unf;
    } vec_t;
    vec_t       tbl[$];
    vec_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] mq;
    logic [3:0] mstk[$];
    logic       movf, munf;
    function automatic vec_t mk(logic e, logic j, logic c, logic r, logic cl, logic [3:0] t,
                                logic [3:0] eq, logic [2:0] esp, logic eo, logic eu);
        vec_t v;
        v.en = e; v.jump = j; v.call = c; v.ret = r; v.clr = cl; v.target = t;
        v.q = eq; v.sp = esp; v.ovf = eo; v.unf = eu;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        mq = 4'd0; mstk.delete(); movf = 1'b0; munf = 1'b0;
    endtask
    task automatic model_step(input vec_t v);
        logic       eo, eu;
        logic [3:0] ra;
        eo = 1'b0; eu = 1'b0;
        if (v.en) begin
            if (v.ret) begin
                if (mstk.size() > 0) mq = mstk.pop_back();
                else begin eu = 1'b1; mq = mq + 4'd1; end
            end else if (v.call) begin
                if (mstk.size() < 4) begin ra = mq + 4'd1; mstk.push_back(ra); mq = v.target; end
                else begin eo = 1'b1; mq = mq + 4'd1; end
            end else if (v.jump) mq = v.target;
            else mq = mq + 4'd1;
        end
        movf = eo | (movf & ~v.clr);
        munf = eu | (munf & ~v.clr);
    endtask
    task automatic apply(input vec_t v, input bit use_tbl);
        vec_t e;
        en = v.en; jump = v.jump; call = v.call; ret = v.ret; clr_err = v.clr; target = v.target;
        model_step(v);
        e = v;
        if (!use_tbl) begin
            e.q = mq; e.sp = 3'(mstk.size()); e.ovf = movf; e.unf = munf;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard empty");
        end else begin
            e = sb.pop_front();
            chk("q", q, e.q);
            chk("sp", sp, e.sp);
            chk("ovf", ovf, e.ovf);
            chk("unf", unf, e.unf);
            chk("full", full, e.sp == 3'd4);
            chk("empty", empty, e.sp == 3'd0);
        end
    endtask
    initial begin
        vec_t v;
        rst = 1'b1; en = 0; jump = 0; call = 0; ret = 0; clr_err = 0; target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q, 0); chk("rst_sp", sp, 0); chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        rst = 1'b0;
        // wrap: 17 increments from 0
        for (int i = 1; i <= 17; i++) tbl.push_back(mk(1,0,0,0,0, 0, 4'(i % 16), 0, 0, 0));
        // underflow then clear
        tbl.push_back(mk(1,1,0,0,0, 6,  6, 0, 0, 0));
        tbl.push_back(mk(1,0,0,1,0, 0,  7, 0, 0, 1));
        tbl.push_back(mk(1,0,0,0,1, 0,  8, 0, 0, 0));
        // nested call/return
        tbl.push_back(mk(1,1,0,0,0, 2,  2, 0, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 9,  9, 1, 0, 0));
        tbl.push_back(mk(1,0,0,0,0, 0, 10, 1, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 5,  5, 2, 0, 0));
        tbl.push_back(mk(1,0,0,1,0, 0, 11, 1, 0, 0));
        tbl.push_back(mk(1,0,0,1,0, 0,  3, 0, 0, 0));
        // overflow: five calls from 0, then unwind to prove contents intact
        tbl.push_back(mk(1,1,0,0,0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 8,  8, 1, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 8,  8, 2, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 8,  8, 3, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 8,  8, 4, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 8,  9, 4, 1, 0));
        tbl.push_back(mk(1,0,0,1,0, 0,  9, 3, 1, 0));
        tbl.push_back(mk(1,0,0,1,0, 0,  9, 2, 1, 0));
        tbl.push_back(mk(1,0,0,1,0, 0,  9, 1, 1, 0));
        tbl.push_back(mk(1,0,0,1,0, 0,  1, 0, 1, 0));
        // en=0 holds, clr_err still acts
        tbl.push_back(mk(0,0,1,0,0, 5,  1, 0, 1, 0));
        tbl.push_back(mk(0,0,0,0,1, 0,  1, 0, 0, 0));
        // priority
        tbl.push_back(mk(1,1,0,0,0, 2,  2, 0, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 7,  7, 1, 0, 0));
        tbl.push_back(mk(1,1,1,1,0,12,  3, 0, 0, 0));
        tbl.push_back(mk(1,0,1,1,0,13,  4, 0, 0, 1));
        tbl.push_back(mk(1,1,1,0,0, 4,  4, 1, 0, 1));
        tbl.push_back(mk(0,0,0,1,0, 0,  4, 1, 0, 1));
        tbl.push_back(mk(1,0,0,1,1, 0,  5, 0, 0, 0));
        tbl.push_back(mk(1,0,0,1,1, 0,  6, 0, 0, 1));
        tbl.push_back(mk(1,0,0,0,1, 0,  7, 0, 0, 0));
        // return address wraps when calling from all-ones
        tbl.push_back(mk(1,1,0,0,0,15, 15, 0, 0, 0));
        tbl.push_back(mk(1,0,1,0,0, 2,  2, 1, 0, 0));
        tbl.push_back(mk(1,0,0,1,0, 0,  0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b1);
        // randomised traffic against the reference model
        for (int i = 0; i < 200; i++) begin
            v = mk($urandom_range(0,9) != 0, $urandom_range(0,3) == 0, $urandom_range(0,2) == 0,
                   $urandom_range(0,2) == 0, $urandom_range(0,7) == 0, 4'($urandom_range(0,15)),
                   0, 0, 0, 0);
            apply(v, 1'b0);
        end
        // asynchronous reset mid-cycle with sp=2, q=12
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        apply(mk(1,0,1,0,0,10, 0, 0, 0, 0), 1'b0);
        apply(mk(1,0,1,0,0,12, 12, 2, 0, 0), 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("arst_q", q, 0); chk("arst_sp", sp, 0); chk("arst_empty", empty, 1);
        chk("arst_ovf", ovf, 0); chk("arst_unf", unf, 0);
        rst = 1'b0;
        model_reset();
        apply(mk(1,0,1,0,0, 6, 6, 1, 0, 0), 1'b1);
        apply(mk(1,0,0,1,0, 0, 1, 0, 0, 0), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 4: program counter and target width in bits; legal range 2..16.
REQ-002 SHALL have parameter DEPTH, default 4: return-address stack entries; legal range 1..16.
REQ-003 SHALL have parameter RESET_VECTOR, default 0: the value q takes on reset.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: advance enable; when 0 all state holds.
REQ-007 SHALL have port jump, input, 1 bit: load target into q.
REQ-008 SHALL have port call, input, 1 bit: push the return address and load target.
REQ-009 SHALL have port ret, input, 1 bit: pop the top of stack into q.
REQ-010 SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-011 SHALL have port target, input, WIDTH bits: jump/call destination.
REQ-012 SHALL have port q, output, WIDTH bits: current program counter, registered.
REQ-013 SHALL have port sp, output, $clog2(DEPTH+1) bits: number of valid stack entries.
REQ-014 SHALL have port full, output, 1 bit: sp == DEPTH (combinational from sp).
REQ-015 SHALL have port empty, output, 1 bit: sp == 0 (combinational from sp).
REQ-016 SHALL have port ovf, output, 1 bit: sticky flag, call attempted while full.
REQ-017 SHALL have port unf, output, 1 bit: sticky flag, ret attempted while empty.

Function
REQ-018 SHALL, when en=0, hold q, sp, stack contents, ovf and unf; clr_err still acts.
REQ-019 SHALL, when en=1, select the operation by priority ret > call > jump > increment; lower-priority requests in the same cycle are ignored.
REQ-020 SHALL, on increment, set q <= q+1 modulo 2^WIDTH (all-ones wraps to 0, no flag).
REQ-021 SHALL, on jump, set q <= target one cycle after the request; the stack is unchanged.
REQ-022 SHALL, on call when not full, write (q+1) mod 2^WIDTH to entry sp, increment sp and set q <= target, all in the same edge.
REQ-023 SHALL, on call when full, leave the stack and sp unchanged, set ovf, and advance q to q+1 (the call becomes an increment).
REQ-024 SHALL, on ret when not empty, set q <= entry sp-1 and decrement sp.
REQ-025 SHALL, on ret when empty, leave sp unchanged, set unf, and advance q to q+1.
REQ-026 SHALL make the stack strictly LIFO, with entry contents undefined above sp; the stack is never read beyond sp-1.
REQ-027 SHALL let a ret in the cycle after a call return the address pushed by that call (no read-after-write hazard).
REQ-028 SHALL, when clr_err=1, clear ovf and unf on that edge; an error event in the same cycle takes precedence (flag ends set).
REQ-029 SHALL keep latency at one cycle for every operation; no stalls or internal states beyond the stack pointer.

Reset
REQ-030 SHALL, while rst=1, immediately and asynchronously force q=RESET_VECTOR, sp=0, ovf=0 and unf=0, irrespective of clk.
REQ-031 SHALL, when reset is applied mid-operation, discard all pending stack contents, and start the first operation after deassertion from RESET_VECTOR with empty=1.
REQ-032 SHALL NOT require stack storage entries to be reset.

Verification
REQ-033 SHALL cover wrap: WIDTH=4, reset, en=1 for 17 cycles -> q steps 0,1..15,0,1; flags stay 0.
REQ-034 SHALL cover nested call/return: from q=2, call target=9; then increment to 10; call target=5; then ret, ret -> q sequence 9,10,5,11,3, with sp going 1,1,2,1,0.
REQ-035 SHALL cover overflow: DEPTH=4, perform 5 calls from q=0 with target=8 -> the fifth call gives q=9, sp=4, ovf=1, and stack contents unchanged.
REQ-036 SHALL cover underflow and clear: ret with empty at q=6 -> q=7, unf=1; then clr_err=1 on the next cycle -> unf=0.
REQ-037 SHALL cover priority: jump, call and ret asserted together with sp=1 and top entry=3 -> q=3, sp=0, target ignored.
REQ-038 SHALL cover async reset: rst pulsed between clock edges with sp=2 and q=12 -> q=0, sp=0 before the next edge; the following call pushes into entry 0.
